// File: rtl/switch_word_loader.sv
// switch_word_loader: builds 32-bit words from the board's slide switches
// and two push-buttons, then writes them to sequential memory addresses
// over a request/ready handshake. The word being assembled is exported so
// the seven-segment mux can display it while the operator works.
module switch_word_loader #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ADDR_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           sw,
    input  logic                  half_sel,
    input  logic                  btn_load,
    input  logic                  btn_commit,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [31:0]           word_preview,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic                  busy,
    output logic                  err
);

    // Counter must hold values up to DEBOUNCE_CYCLES-1; keep at least one bit.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] WRITTEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    // Synchroniser stages; button index 0 is load, index 1 is commit.
    logic [15:0]           r_swMeta;
    logic [15:0]           r_swSync;
    logic                  r_halfMeta;
    logic                  r_halfSync;
    logic [1:0]            r_btnMeta;
    logic [1:0]            r_btnSync;

    // Debounce state per button.
    logic [CW-1:0]         r_btnCnt [2];
    logic [1:0]            r_btnDeb;
    logic [1:0]            r_btnPress;

    // Loader state and registered outputs.
    state_t                r_state;
    logic                  r_loValid;
    logic                  r_hiValid;
    logic                  r_memWe;
    logic [ADDR_WIDTH-1:0] r_memAddr;
    logic [31:0]           r_memWdata;
    logic [31:0]           r_wordPreview;
    logic [ADDR_WIDTH:0]   r_wordsWritten;
    logic                  r_busy;
    logic                  r_err;

    logic [1:0]            w_btnRaw;
    logic                  w_loadPress;
    logic                  w_commitPress;

    assign w_btnRaw      = {btn_commit, btn_load};
    assign w_loadPress   = r_btnPress[0];
    assign w_commitPress = r_btnPress[1];

    // Two-flop synchronisers bring every board input into the clk domain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_swMeta   <= '0;
            r_swSync   <= '0;
            r_halfMeta <= 1'b0;
            r_halfSync <= 1'b0;
            r_btnMeta  <= '0;
            r_btnSync  <= '0;
        end else begin
            r_swMeta   <= sw;
            r_swSync   <= r_swMeta;
            r_halfMeta <= half_sel;
            r_halfSync <= r_halfMeta;
            r_btnMeta  <= w_btnRaw;
            r_btnSync  <= r_btnMeta;
        end
    end

    // Debounce each button and emit a one-cycle pulse when it settles pressed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                r_btnCnt[b] <= '0;
            end
            r_btnDeb   <= '0;
            r_btnPress <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                r_btnPress[b] <= 1'b0;
                if (r_btnSync[b] == r_btnDeb[b]) begin
                    r_btnCnt[b] <= '0;
                end else if (r_btnCnt[b] == CNT_LAST) begin
                    r_btnDeb[b]   <= ~r_btnDeb[b];
                    r_btnCnt[b]   <= '0;
                    r_btnPress[b] <= ~r_btnDeb[b];
                end else begin
                    r_btnCnt[b] <= r_btnCnt[b] + CW'(1);
                end
            end
        end
    end

    // Loader FSM: assemble halves in IDLE, hold the write request in WRITE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_loValid      <= 1'b0;
            r_hiValid      <= 1'b0;
            r_memWe        <= 1'b0;
            r_memAddr      <= '0;
            r_memWdata     <= '0;
            r_wordPreview  <= '0;
            r_wordsWritten <= '0;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_loadPress) begin
                        if (r_halfSync) begin
                            r_wordPreview[31:16] <= r_swSync;
                            r_hiValid            <= 1'b1;
                        end else begin
                            r_wordPreview[15:0] <= r_swSync;
                            r_loValid           <= 1'b1;
                        end
                        r_err <= 1'b0;
                    end else if (w_commitPress) begin
                        if (r_loValid && r_hiValid) begin
                            r_memWdata <= r_wordPreview;
                            r_memWe    <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= WRITE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        r_memWe   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_loValid <= 1'b0;
                        r_hiValid <= 1'b0;
                        r_memAddr <= r_memAddr + 1'b1;
                        if (r_wordsWritten != WRITTEN_MAX) begin
                            r_wordsWritten <= r_wordsWritten + 1'b1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_we        = r_memWe;
    assign mem_addr      = r_memAddr;
    assign mem_wdata     = r_memWdata;
    assign word_preview  = r_wordPreview;
    assign words_written = r_wordsWritten;
    assign busy          = r_busy;
    assign err           = r_err;

endmodule

// File: tb/tb_switch_word_loader.sv
// Bench for switch_word_loader with a short debounce and a four-word memory.
// Expected writes go into a queue when a commit is issued; a monitor pops
// and compares whenever the DUT hands a write to the memory.
module tb_switch_word_loader;

    localparam int DEB = 4;
    localparam int AW  = 2;

    logic          clk;
    logic          reset;
    logic [15:0]   sw;
    logic          half_sel;
    logic          btn_load;
    logic          btn_commit;
    logic          mem_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   word_preview;
    logic [AW:0]   words_written;
    logic          busy;
    logic          err;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t expQ[$];
    int  testsRun  = 0;
    int  failCount = 0;
    int  weCycles  = 0;

    switch_word_loader #(
        .DEBOUNCE_CYCLES(DEB),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw),
        .half_sel(half_sel),
        .btn_load(btn_load),
        .btn_commit(btn_commit),
        .mem_ready(mem_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .word_preview(word_preview),
        .words_written(words_written),
        .busy(busy),
        .err(err)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Press and release buttons, each phase long enough to debounce.
    task automatic applyStimulus(input logic ld, input logic cm, input int hold);
        btn_load   = ld;
        btn_commit = cm;
        tick(hold);
        btn_load   = 1'b0;
        btn_commit = 1'b0;
        tick(hold);
    endtask

    task automatic loadHalf(input logic half, input logic [15:0] value);
        half_sel = half;
        sw       = value;
        tick(3);
        applyStimulus(1'b1, 1'b0, 8);
    endtask

    task automatic waitForWe();
        for (int i = 0; i < 50; i++) begin
            if (mem_we) break;
            tick(1);
        end
        checkOutput("we_rise_timeout", {31'd0, mem_we}, 32'd1);
    endtask

    // Monitor: a request seen with ready high is accepted at the next edge.
    always @(negedge clk) begin
        if (reset && mem_we) begin
            weCycles++;
            if (mem_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_write", {30'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = expQ.pop_front();
                    checkOutput("write_addr", {30'd0, mem_addr}, {30'd0, e.addr});
                    checkOutput("write_data", mem_wdata, e.data);
                end
            end
        end
    end

    initial begin
        wr_t w;
        reset      = 1'b0;
        sw         = 16'h0000;
        half_sel   = 1'b0;
        btn_load   = 1'b0;
        btn_commit = 1'b0;
        mem_ready  = 1'b0;
        tick(2);

        checkOutput("rst_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_addr", {30'd0, mem_addr}, 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        checkOutput("rst_preview", word_preview, 32'd0);
        checkOutput("rst_written", {29'd0, words_written}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b1;
        tick(1);

        // A two-cycle bounce must not register as a press.
        sw = 16'h7777;
        tick(3);
        applyStimulus(1'b1, 1'b0, 2);
        tick(6);
        checkOutput("bounce_preview", word_preview, 32'd0);

        // Build and write the first word with ready already high.
        loadHalf(1'b0, 16'h1234);
        checkOutput("load_lo", word_preview, 32'h0000_1234);
        loadHalf(1'b1, 16'hABCD);
        checkOutput("load_hi", word_preview, 32'hABCD_1234);
        mem_ready = 1'b1;
        w.addr = 2'd0; w.data = 32'hABCD_1234; expQ.push_back(w);
        weCycles = 0;
        applyStimulus(1'b0, 1'b1, 8);
        checkOutput("one_we_cycle", weCycles, 32'd1);
        checkOutput("addr_after_1", {30'd0, mem_addr}, 32'd1);
        checkOutput("written_1", {29'd0, words_written}, 32'd1);
        checkOutput("busy_after_1", {31'd0, busy}, 32'd0);

        // Commit with only the low half reloaded raises err without writing.
        loadHalf(1'b0, 16'h5555);
        checkOutput("preview_keeps_hi", word_preview, 32'hABCD_5555);
        weCycles = 0;
        applyStimulus(1'b0, 1'b1, 8);
        checkOutput("err_set", {31'd0, err}, 32'd1);
        checkOutput("no_write_on_err", weCycles, 32'd0);
        loadHalf(1'b1, 16'h6666);
        checkOutput("err_cleared", {31'd0, err}, 32'd0);
        checkOutput("preview_2", word_preview, 32'h6666_5555);

        // Stalled write: extra presses must be ignored while waiting.
        mem_ready = 1'b0;
        w.addr = 2'd1; w.data = 32'h6666_5555; expQ.push_back(w);
        btn_commit = 1'b1;
        waitForWe();
        tick(8);
        btn_commit = 1'b0;
        tick(8);
        checkOutput("stall_addr", {30'd0, mem_addr}, 32'd1);
        checkOutput("stall_data", mem_wdata, 32'h6666_5555);
        loadHalf(1'b0, 16'hFFFF);
        applyStimulus(1'b0, 1'b1, 8);
        checkOutput("stall_we", {31'd0, mem_we}, 32'd1);
        checkOutput("stall_busy", {31'd0, busy}, 32'd1);
        checkOutput("stall_addr_hold", {30'd0, mem_addr}, 32'd1);
        checkOutput("stall_data_hold", mem_wdata, 32'h6666_5555);
        checkOutput("stall_preview", word_preview, 32'h6666_5555);
        mem_ready = 1'b1;
        tick(3);
        checkOutput("stall_done_we", {31'd0, mem_we}, 32'd0);
        checkOutput("addr_after_2", {30'd0, mem_addr}, 32'd2);
        checkOutput("written_2", {29'd0, words_written}, 32'd2);

        // Fresh start, then five writes: addresses wrap and the count saturates.
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [31:0] exp_ww;
            loadHalf(1'b0, 16'h2000 + 16'(i));
            loadHalf(1'b1, 16'h1000 + 16'(i));
            w.addr = 2'(i);
            w.data = {16'h1000 + 16'(i), 16'h2000 + 16'(i)};
            expQ.push_back(w);
            applyStimulus(1'b0, 1'b1, 8);
            exp_ww = (i < 4) ? 32'(i + 1) : 32'd4;
            checkOutput("seq_written", {29'd0, words_written}, exp_ww);
        end
        checkOutput("seq_addr_wrap", {30'd0, mem_addr}, 32'd1);

        // Reset while a write is pending abandons it.
        mem_ready = 1'b0;
        loadHalf(1'b0, 16'hCAFE);
        loadHalf(1'b1, 16'hBEEF);
        btn_commit = 1'b1;
        waitForWe();
        reset = 1'b0;
        tick(1);
        checkOutput("abort_we", {31'd0, mem_we}, 32'd0);
        checkOutput("abort_addr", {30'd0, mem_addr}, 32'd0);
        checkOutput("abort_written", {29'd0, words_written}, 32'd0);
        checkOutput("abort_preview", word_preview, 32'd0);
        checkOutput("abort_err", {31'd0, err}, 32'd0);
        btn_commit = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(4);

        checkOutput("queue_drained", expQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/switch_word_loader.md
Name: switch_word_loader

Overview:
- Board-input counterpart of the seven-segment output path.
- The operator builds 32-bit words from 16 slide switches and two push-buttons, then writes them sequentially into a memory, e.g. instruction memory before the multicycle core runs.
- A request/ready handshake drives the write port.
- The word being assembled is exported so the display mux can show it.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable samples required to accept a button level (10 ms at 100 MHz).
- ADDR_WIDTH, 8: width of the word address; memory depth is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-low reset.
- sw  input  16  slide-switch value, asynchronous to clk.
- half_sel  input  1  0 = load into bits [15:0], 1 = load into bits [31:16]; asynchronous to clk.
- btn_load  input  1  raw push-button: latch sw into the selected half.
- btn_commit  input  1  raw push-button: write the assembled word to memory.
- mem_ready  input  1  memory accepted the write; sampled only while mem_we=1.
- mem_we  output  1  write request, held until accepted.
- mem_addr  output  ADDR_WIDTH  write address.
- mem_wdata  output  32  write data.
- word_preview  output  32  word currently being assembled.
- words_written  output  ADDR_WIDTH+1  count of accepted writes, saturating.
- busy  output  1  a write is in progress.
- err  output  1  sticky: commit was attempted with an incomplete word.

Behaviour:
- Reset (reset=0 at a clk edge) values:
  - mem_we=0, mem_addr=0, mem_wdata=0, word_preview=0, words_written=0, busy=0, err=0.
  - lo_valid=0, hi_valid=0; state=IDLE.
  - Debounce counters=0; debounced levels=0.
- Reset has priority over everything. Reset during WRITE drops mem_we in the same edge; the write is abandoned and not counted.
- Input synchronisation:
  - sw, half_sel, btn_load and btn_commit each pass through a 2-flop synchroniser.
  - sw and half_sel are not debounced.
- Debounce, per button:
  - The counter counts while the synchronised level differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A 0→1 transition of the debounced level produces one press pulse, one clk wide.
  - Releases produce no pulse.
- Load (press pulse on btn_load, state IDLE):
  - half_sel=0: word_preview[15:0] <= synchronised sw; lo_valid <= 1.
  - half_sel=1: word_preview[31:16] <= synchronised sw; hi_valid <= 1.
  - err <= 0.
  - Reloading a half that is already valid overwrites it.
- Commit (press pulse on btn_commit, state IDLE):
  - lo_valid & hi_valid: mem_wdata <= word_preview, mem_we <= 1, busy <= 1, state <= WRITE.
  - Otherwise: err <= 1, no other change.
- Simultaneous load and commit pulses in the same cycle: load wins and commit is dropped.
- WRITE state:
  - mem_we, mem_addr and mem_wdata are held stable until a cycle with mem_ready=1.
  - At that edge: mem_we <= 0, busy <= 0, lo_valid <= 0, hi_valid <= 0, word_preview unchanged.
  - mem_addr <= mem_addr+1, wrapping from 2^ADDR_WIDTH-1 to 0.
  - words_written increments, saturating at 2^ADDR_WIDTH.
  - state <= IDLE.
- All press pulses arriving in WRITE are discarded; there is no queueing.
- Minimum latency from commit pulse to mem_we=1 is 1 cycle. An accepted write completes in the cycle mem_ready is high. A mem_ready already high at entry to WRITE is sampled on the next edge, so the write occupies mem_we for 1 cycle.
- mem_ready is ignored in IDLE.

Test Plan:
- DEBOUNCE_CYCLES=4, ADDR_WIDTH=2. Apply reset=0 for 2 cycles, then raise btn_load for 2 cycles only -> no load; word_preview=0, lo_valid=0.
- half_sel=0, sw=16'h1234, btn_load held 8 cycles; then half_sel=1, sw=16'hABCD, load again; btn_commit pressed with mem_ready tied 1 -> exactly one mem_we cycle, mem_addr=0, mem_wdata=32'hABCD1234; afterwards mem_addr=1, words_written=1.
- Commit after loading only the low half -> err=1 and mem_we stays 0. A subsequent btn_load clears err to 0.
- mem_ready held 0 for 10 cycles during WRITE, with extra btn_load/btn_commit presses -> mem_we, mem_addr and mem_wdata remain stable and the presses are ignored. Raising mem_ready completes a single write.
- Five full load/commit sequences with ADDR_WIDTH=2 -> addresses 0,1,2,3,0 in order; words_written saturates at 4.
- Pull reset low while mem_we=1 -> next cycle mem_we=0, mem_addr=0, words_written=0, word_preview=0, err=0.
